// File: rtl/bp_fe_fetch_splitter.sv
// Fetch splitter: re-cuts a stream of 32-bit instructions at 2-byte-aligned
// PCs into 4-byte-aligned fetch words. A misaligned instruction leaves its
// upper half pending in a carry register. That half is merged with the lower
// half of the next contiguous instruction, or emitted alone as a drain word
// when the run ends.

package bp_fe_splitter_pkg;

  localparam int instr_width_gp = 32;

  // Processor configurations understood by this block; only the virtual
  // address width matters here.
  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_sv48_cfg    = 2'd1,
    e_bp_sv32_cfg    = 2'd2
  } bp_params_e;

  function automatic int vaddr_width_f(input bp_params_e cfg);
    case (cfg)
      e_bp_sv48_cfg: return 48;
      e_bp_sv32_cfg: return 32;
      default:       return 39;
    endcase
  endfunction

  // e_ready : no half pending
  // e_carry : upper half of the previous instruction is held in carry_r
  // e_drain : held half must be emitted on its own; no input is accepted
  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_carry = 2'd1,
    e_drain = 2'd2
  } splitter_state_e;

endpackage

module bp_fe_fetch_splitter
  import bp_fe_splitter_pkg::*;
#(
  parameter bp_params_e bp_params_p   = e_bp_default_cfg,
  localparam int        vaddr_width_p = vaddr_width_f(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic                      instr_v_i,
  input  logic [vaddr_width_p-1:0]  instr_pc_i,
  input  logic [instr_width_gp-1:0] instr_i,
  input  logic                      instr_last_i,
  output logic                      instr_ready_and_o,

  input  logic                      poison_i,

  output logic                      word_v_o,
  output logic [vaddr_width_p-1:0]  word_pc_o,
  output logic [31:0]               word_data_o,
  output logic                      word_branch_site_o,
  input  logic                      word_ready_and_i,

  output logic                      err_o
);

  // One halfword step in PC space; all PC arithmetic wraps at vaddr_width_p.
  localparam logic [vaddr_width_p-1:0] half_step_lp = vaddr_width_p'(2);

  splitter_state_e            state_r, state_n;
  logic [15:0]                carry_r;
  logic [vaddr_width_p-1:0]   carry_pc_r;
  logic                       err_r;

  logic                       w_in_carry;
  logic                       w_in_drain;
  logic                       w_misaligned;
  logic [vaddr_width_p-1:0]   w_carry_next_pc;
  logic                       w_discontinuity;
  logic                       w_live;
  logic                       w_instr_fire;
  logic                       w_load_carry;

  assign w_in_carry      = (state_r == e_carry);
  assign w_in_drain      = (state_r == e_drain);
  assign w_misaligned    = instr_pc_i[1];

  // The only instruction that continues a pending carry starts one halfword
  // after the held half.
  assign w_carry_next_pc = carry_pc_r + half_step_lp;
  assign w_discontinuity = w_in_carry & instr_v_i & (instr_pc_i != w_carry_next_pc);

  // Reset and poison both silence the handshakes in the cycle they appear.
  assign w_live          = reset_n_i & ~poison_i;

  assign w_instr_fire    = instr_v_i & instr_ready_and_o;

  // Every accepted instruction in e_carry is contiguous and therefore
  // misaligned, so it always leaves a new upper half behind.
  assign w_load_carry    = w_instr_fire & (w_in_carry | w_misaligned);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values and simulation matches the synthesised
  // netlist regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state decision: poison wins over everything, then the per-state rules.
  // NOTE: the next-state value is given a default before any branch so the
  // combinational block covers every path and no latch is inferred.
  always_comb begin
    state_n = state_r;
    if (poison_i) begin
      state_n = e_ready;
    end else begin
      case (state_r)
        e_ready: begin
          if (w_instr_fire && w_misaligned) begin
            state_n = instr_last_i ? e_drain : e_carry;
          end
        end
        e_carry: begin
          if (w_discontinuity) begin
            state_n = e_drain;
          end else if (w_instr_fire) begin
            state_n = instr_last_i ? e_drain : e_carry;
          end
        end
        e_drain: begin
          if (word_ready_and_i) begin
            state_n = e_ready;
          end
        end
        default: state_n = e_ready;
      endcase
    end
  end

  // Output decode: handshakes plus the word assembled for the current state.
  always_comb begin
    // A discontinuous instruction is refused outright; the held half drains
    // first and the instruction is taken again from e_ready.
    instr_ready_and_o  = w_live & word_ready_and_i & ~w_in_drain & ~w_discontinuity;
    word_v_o           = w_live & (w_in_drain | (instr_v_i & ~w_discontinuity));

    word_pc_o          = instr_pc_i;
    word_data_o        = instr_i;
    word_branch_site_o = instr_last_i;

    case (state_r)
      e_ready: begin
        if (w_misaligned) begin
          // Only the lower instruction half lands in this word (upper slot).
          word_data_o        = {instr_i[15:0], 16'h0000};
          word_branch_site_o = 1'b0;
        end
      end
      e_carry: begin
        word_pc_o          = carry_pc_r;
        word_data_o        = {instr_i[15:0], carry_r};
        word_branch_site_o = 1'b0;
      end
      e_drain: begin
        word_pc_o          = carry_pc_r;
        word_data_o        = {16'h0000, carry_r};
        word_branch_site_o = 1'b1;
      end
      default: begin
        word_pc_o          = instr_pc_i;
      end
    endcase
  end

  // Carry datapath: capture the upper half of each misaligned instruction.
  // NOTE: the carry registers are reset explicitly so a half pending when
  // reset arrives can never leak into the first word of the next run.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      carry_r    <= 16'h0000;
      carry_pc_r <= '0;
    end else if (poison_i) begin
      carry_r    <= 16'h0000;
    end else if (w_load_carry) begin
      carry_r    <= instr_i[31:16];
      carry_pc_r <= instr_pc_i + half_step_lp;
    end
  end

  // Sticky protocol-error flag, raised by a discontinuity inside a run.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      err_r <= 1'b0;
    end else if (w_discontinuity && !poison_i) begin
      err_r <= 1'b1;
    end
  end

  assign err_o = err_r;

endmodule

// File: doc/bp_fe_fetch_splitter.md
BP_FE_FETCH_SPLITTER -- requirements
Module: bp_fe_fetch_splitter

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, which selects the processor configuration; vaddr_width_p derives from it.
REQ-002 SHALL have clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have reset_n_i, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have instr_v_i, input, 1 bit: instruction offered.
REQ-005 SHALL have instr_pc_i, input, vaddr_width_p bits: instruction PC, 2-byte aligned.
REQ-006 SHALL have instr_i, input, instr_width_gp (32) bits: full instruction.
REQ-007 SHALL have instr_last_i, input, 1 bit: last instruction of a contiguous run.
REQ-008 SHALL have instr_ready_and_o, output, 1 bit: instruction accepted when high with instr_v_i.
REQ-009 SHALL have poison_i, input, 1 bit: discard the pending half and the run state.
REQ-010 SHALL have word_v_o, output, 1 bit: fetch word valid.
REQ-011 SHALL have word_pc_o, output, vaddr_width_p bits: fetch PC.
REQ-012 SHALL have word_data_o, output, 32 bits: 4-byte-aligned fetch word.
REQ-013 SHALL have word_branch_site_o, output, 1 bit: upper half of the word does not continue the stream.
REQ-014 SHALL have word_ready_and_i, input, 1 bit: consumer accepts the word.
REQ-015 SHALL have err_o, output, 1 bit: sticky protocol-error flag.

Function
REQ-016 SHALL split a stream of 32-bit instructions at 2-byte-aligned PCs into 4-byte-aligned fetch words, so that a halves-realigning fetch consumer reconstructs the original stream.
REQ-017 SHALL implement states e_ready (no carry), e_carry (upper half held) and e_drain (held half must be emitted, no input accepted).
REQ-018 SHALL hold a 16-bit carry_r and a vaddr_width_p-bit carry_pc_r.
REQ-019 SHALL drive instr_ready_and_o = word_ready_and_i & (state != e_drain) & ~poison_i, and drive word_v_o = (state == e_drain) | (instr_v_i & ~poison_i & ~discontinuity); transfer is combinational with 0 latency.
REQ-020 SHALL, in e_ready, for an aligned instruction (pc[1]=0): word_pc_o = pc, word_data_o = instr_i, word_branch_site_o = instr_last_i; state stays e_ready.
REQ-021 SHALL, in e_ready, for a misaligned instruction (pc[1]=1): word_pc_o = pc, word_data_o = {instr_i[15:0], 16'h0}, word_branch_site_o = 0; on accept, carry_r <= instr_i[31:16], carry_pc_r <= pc+2, and next state is e_drain if instr_last_i, else e_carry.
REQ-022 SHALL, in e_carry with instr_pc_i == carry_pc_r+2: word_pc_o = carry_pc_r, word_data_o = {instr_i[15:0], carry_r}, word_branch_site_o = 0; on accept, carry_r <= instr_i[31:16], carry_pc_r <= instr_pc_i+2, and next state is e_drain if instr_last_i, else e_carry.
REQ-023 SHALL, in e_carry with instr_v_i and instr_pc_i != carry_pc_r+2 (discontinuity): not accept; set err_o; go to e_drain.
REQ-024 SHALL, in e_drain: word_v_o = 1, word_pc_o = carry_pc_r, word_data_o = {16'h0, carry_r}, word_branch_site_o = 1; on word_ready_and_i, go to e_ready; instr_i is ignored.
REQ-025 SHALL keep err_o high once set, until reset.
REQ-026 SHALL, on poison_i, force word_v_o = 0 and instr_ready_and_o = 0 that cycle, go to e_ready next cycle, and clear carry_r to 0; poison_i overrides all handshakes, including in e_drain.
REQ-027 SHALL compute PC arithmetic modulo 2^vaddr_width_p, wrapping without error.
REQ-028 SHALL hold every output and state stable while word_v_o is high and word_ready_and_i is low.

Reset
REQ-029 SHALL, while reset_n_i is sampled low, enter e_ready with carry_r = 0, carry_pc_r = 0 and err_o = 0.
REQ-030 SHALL hold word_v_o = 0 and instr_ready_and_o = 0 during reset; a reset mid-run discards any carry without emitting it.

Verification
REQ-031 Aligned instructions at 0x1000 (0x00000013) and 0x1004 (0x00100093, last) SHALL produce words 0x1000/0x00000013/bs=0, then 0x1004/0x00100093/bs=1, with state e_ready throughout.
REQ-032 Misaligned instructions at 0x1002 (0xAAAA5555) and 0x1006 (0xCCCC3333, last) SHALL produce 0x1002/0x55550000/bs0, then 0x1004/0x3333AAAA/bs0, then drain 0x1008/0x0000CCCC/bs1, with instr_ready_and_o low during the drain.
REQ-033 In e_carry with carry_pc_r=0x2004, offering pc=0x3000 SHALL be refused, raise err_o, and emit drain 0x2004/{0,carry}/bs1; pc=0x3000 is then accepted in e_ready.
REQ-034 Holding word_ready_and_i low 3 cycles in e_drain SHALL keep word_v_o and all outputs stable, then exit to e_ready one cycle after ready rises.
REQ-035 Asserting poison_i in e_carry and in e_drain SHALL emit no word and return to e_ready; the next misaligned instruction SHALL show lower half 16'h0.
REQ-036 Asserting reset_n_i low mid-run with a carry pending SHALL clear err_o, emit no drain word, and leave word_v_o low.
